// File: rtl/stream_deserializer.sv
// Word-to-frame deserializer: gathers up to N words into one parallel frame.
// Supports start-of-frame realignment, selectable slot order and a one-frame skid on backpressure.
module stream_deserializer #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ORDER      = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_WIDTH-1:0]     i_data,
  input  logic                      i_valid,
  input  logic                      i_sof,
  input  logic [$clog2(N+1)-1:0]    i_len,
  output logic                      o_ready,
  output logic [N*DATA_WIDTH-1:0]   o_data,
  output logic [$clog2(N+1)-1:0]    o_count,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_err
);

  localparam int LW = $clog2(N+1);

  typedef enum logic {ST_ACC, ST_HOLD} state_e;
  typedef logic [N-1:0][DATA_WIDTH-1:0] frame_t;

  state_e        state_q;
  logic [LW-1:0] idx_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] count_q;
  frame_t        acc_q;
  frame_t        data_q;
  logic          valid_q;
  logic          err_q;

  logic          accept;
  logic          free;
  logic          restart;
  logic          last;
  logic [LW-1:0] eff_len;
  logic [LW-1:0] cur_len;
  logic [LW-1:0] cur_idx;
  logic [LW-1:0] slot;
  frame_t        acc_d;
  frame_t        frame_d;
  frame_t        hold_frame_d;

  // Slots at or beyond the frame length are delivered as zero.
  function automatic frame_t mask_frame(input frame_t f, input logic [LW-1:0] len);
    frame_t m;
    m = '0;
    for (int k = 0; k < N; k++) begin
      if (LW'(k) < len) m[k] = f[k];
    end
    return m;
  endfunction

  assign o_ready = (state_q == ST_ACC) && !i_rst;
  assign o_data  = data_q;
  assign o_count = count_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    accept  = i_valid && o_ready;
    free    = !valid_q || i_ready;
    restart = (idx_q == '0) || i_sof;
    eff_len = ((i_len == '0) || (i_len > LW'(N))) ? LW'(N) : i_len;
    cur_len = restart ? eff_len : len_q;
    cur_idx = restart ? '0 : idx_q;
    last    = (cur_idx == cur_len - LW'(1));
    slot    = (ORDER != 0) ? (cur_len - LW'(1) - cur_idx) : cur_idx;

    acc_d = acc_q;
    for (int k = 0; k < N; k++) begin
      if (LW'(k) == slot) acc_d[k] = i_data;
    end
    frame_d      = mask_frame(acc_d, cur_len);
    hold_frame_d = mask_frame(acc_q, len_q);
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments
  // in the same block override earlier defaults (e.g. valid_q load beats clear).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_ACC;
      idx_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      // NOTE: the accumulator is reset too; it is small and keeps its contents deterministic.
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && i_sof && (idx_q != '0);
      if (i_ready) valid_q <= 1'b0;

      unique case (state_q)
        ST_ACC: begin
          if (accept) begin
            len_q <= cur_len;
            if (last) begin
              idx_q <= '0;
              if (free) begin
                data_q  <= frame_d;
                count_q <= cur_len;
                valid_q <= 1'b1;
              end else begin
                acc_q   <= acc_d;
                state_q <= ST_HOLD;
              end
            end else begin
              acc_q <= acc_d;
              idx_q <= cur_idx + LW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (free) begin
            data_q  <= hold_frame_d;
            count_q <= len_q;
            valid_q <= 1'b1;
            idx_q   <= '0;
            state_q <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_deserializer.sv
// Directed bench for stream_deserializer: two instances (ORDER=0 and ORDER=1) share one stimulus.
module tb_stream_deserializer;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_data;
  logic        i_valid;
  logic        i_sof;
  logic [2:0]  i_len;
  logic        i_ready;

  logic        rdy0, rdy1, val0, val1, err0, err1;
  logic [63:0] dat0, dat1;
  logic [2:0]  cnt0, cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_deserializer #(.N(4), .DATA_WIDTH(16), .ORDER(0)) dut0 (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .i_sof(i_sof),
    .i_len(i_len), .o_ready(rdy0), .o_data(dat0), .o_count(cnt0), .o_valid(val0),
    .i_ready(i_ready), .o_err(err0)
  );

  stream_deserializer #(.N(4), .DATA_WIDTH(16), .ORDER(1)) dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .i_sof(i_sof),
    .i_len(i_len), .o_ready(rdy1), .o_data(dat1), .o_count(cnt1), .o_valid(val1),
    .i_ready(i_ready), .o_err(err1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word for one clock edge; outputs are sampled 1 time unit after the edge.
  task automatic send(input logic [15:0] d, input logic sof);
    i_data  = d;
    i_sof   = sof;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] w [4];

    i_rst = 1'b1; i_data = '0; i_valid = 1'b0; i_sof = 1'b0; i_len = 3'd4; i_ready = 1'b1;
    idle();
    idle();
    check("rst_valid", val0, 0);
    check("rst_data",  dat0, 0);
    check("rst_count", cnt0, 0);
    check("rst_err",   err0, 0);
    check("rst_ready", rdy0, 0);
    i_rst = 1'b0;
    #1;
    check("ready_after_release", rdy0, 1);
    idle();

    // Basic 4-word frame
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b0);
    check("basic_not_yet", val0, 0);
    send(16'h4444, 1'b0);
    check("basic_valid",    val0, 1);
    check("basic_data",     dat0, 64'h4444_3333_2222_1111);
    check("basic_count",    cnt0, 4);
    check("basic_rev_data", dat1, 64'h1111_2222_3333_4444);

    // Three back-to-back frames: o_valid only in the cycle after each last word
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        w[k] = 16'h1000 * 16'(f + 1) + 16'(k);
        send(w[k], 1'b0);
        check("stream_ready", rdy0, 1);
        check("stream_valid", val0, (k == 3) ? 64'd1 : 64'd0);
      end
      check("stream_data", dat0, {w[3], w[2], w[1], w[0]});
    end
    idle();
    check("idle_valid_clear", val0, 0);

    // Short frame, reversed order on dut1
    i_len = 3'd2;
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b0);
    check("short_valid",    val1, 1);
    check("short_rev_data", dat1, 64'h0000_0000_AAAA_BBBB);
    check("short_rev_cnt",  cnt1, 2);
    check("short_fwd_data", dat0, 64'h0000_0000_BBBB_AAAA);

    // i_len=0 means N; i_len changes mid-frame are ignored
    i_len = 3'd0;
    send(16'h0001, 1'b0);
    i_len = 3'd1;
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b0);
    check("len0_not_yet", val0, 0);
    send(16'h0004, 1'b0);
    check("len0_valid",    val1, 1);
    check("len0_count",    cnt1, 4);
    check("len0_rev_data", dat1, 64'h0001_0002_0003_0004);

    // Single-word frame
    send(16'h5555, 1'b0);
    check("len1_valid",    val0, 1);
    check("len1_count",    cnt0, 1);
    check("len1_data",     dat0, 64'h0000_0000_0000_5555);
    check("len1_rev_data", dat1, 64'h0000_0000_0000_5555);
    idle();

    // Backpressure; i_len=5 exceeds N and means 4
    i_len = 3'd5;
    i_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      send(16'hB000 + 16'(k), 1'b0);
      if (k == 7) check("bp_ready_w7", rdy0, 1);
    end
    check("bp_ready_low", rdy0, 0);
    i_data = 16'hB009; i_valid = 1'b1;
    idle();
    idle();
    check("bp_stall_ready", rdy0, 0);
    check("bp_stall_valid", val0, 1);
    check("bp_stall_data",  dat0, 64'hB004_B003_B002_B001);
    i_ready = 1'b1;
    idle();
    i_ready = 1'b0;
    check("bp_f2_valid", val0, 1);
    check("bp_f2_data",  dat0, 64'hB008_B007_B006_B005);
    check("bp_f2_count", cnt0, 4);
    check("bp_f2_ready", rdy0, 1);
    send(16'hB009, 1'b0);
    send(16'hB00A, 1'b0);
    send(16'hB00B, 1'b0);
    send(16'hB00C, 1'b0);
    check("bp2_ready_low", rdy0, 0);
    check("bp2_data_hold", dat0, 64'hB008_B007_B006_B005);
    i_ready = 1'b1;
    idle();
    check("bp_f3_data",  dat0, 64'hB00C_B00B_B00A_B009);
    check("bp_f3_ready", rdy0, 1);
    idle();
    check("bp_drained", val0, 0);

    // Realignment on i_sof
    i_len = 3'd4;
    send(16'h0001, 1'b1);
    check("sof_idx0_no_err", err0, 0);
    send(16'h0002, 1'b0);
    send(16'h0009, 1'b1);
    check("realign_err", err0, 1);
    send(16'h000A, 1'b0);
    check("realign_err_pulse", err0, 0);
    send(16'h000B, 1'b0);
    check("realign_not_yet", val0, 0);
    send(16'h000C, 1'b0);
    check("realign_valid",    val0, 1);
    check("realign_data",     dat0, 64'h000C_000B_000A_0009);
    check("realign_rev_data", dat1, 64'h0009_000A_000B_000C);
    idle();

    // Asynchronous reset with a frame pending and 2 words of a partial frame
    i_ready = 1'b0;
    send(16'hE001, 1'b0);
    send(16'hE002, 1'b0);
    send(16'hE003, 1'b0);
    send(16'hE004, 1'b0);
    send(16'hE005, 1'b0);
    send(16'hE006, 1'b0);
    check("pre_rst_valid", val0, 1);
    #3 i_rst = 1'b1;
    #1;
    check("arst_valid", val0, 0);
    check("arst_data",  dat0, 0);
    check("arst_count", cnt0, 0);
    check("arst_ready", rdy0, 0);
    #2 i_rst = 1'b0;
    i_ready = 1'b1;
    idle();
    check("post_rst_ready", rdy0, 1);
    check("post_rst_valid", val0, 0);
    send(16'h0D01, 1'b0);
    send(16'h0D02, 1'b0);
    send(16'h0D03, 1'b0);
    send(16'h0D04, 1'b0);
    check("post_rst_fvalid", val0, 1);
    check("post_rst_data",   dat0, 64'h0D04_0D03_0D02_0D01);
    check("post_rst_count",  cnt0, 4);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
